// File: rtl/pcs_gearbox_tx.sv
// pcs_gearbox_tx: packs 66-bit {payload, sync header} blocks into 64-bit
// words, 32 blocks in -> 33 words out. Option macro: PCS_TX_HEAD_CHECK_EN.
module pcs_gearbox_tx #(
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2,
  parameter int SEQ_W  = 6
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
`ifdef PCS_TX_HEAD_CHECK_EN
  output logic              head_err_o,
`endif
  output logic [DATA_W-1:0] data_o
);

  localparam int BLK_W = DATA_W + HEAD_W;
  localparam int CAT_W = DATA_W + BLK_W;
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [SEQ_W-1:0] SEQ_FLUSH =
    SEQ_W'(DATA_W / HEAD_W);

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
`ifdef PCS_TX_HEAD_CHECK_EN
  logic              herr_q, herr_d;
  logic              head_bad;
`endif

  logic              flush;
  logic              accept;
  logic [BLK_W-1:0]  blk;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] lo_mask;
  logic [DATA_W-1:0] lo_vld;
  logic [CAT_W-1:0]  cat;
  logic [SH_W:0][CAT_W-1:0] stg;
  logic              unused_cat;

  assign flush   = (seq_q == SEQ_FLUSH);
  assign ready_o = nreset & ~flush;
  assign accept  = valid_i & ready_o;
  assign blk     = {data_i, head_i};

  // bit offset of the new block: two leftover bits per block so far
  assign shamt = {seq_q[SH_W-2:0], 1'b0};

  // log-stage barrel shifter placing the block above the leftover bits
  always_comb begin
    stg[0] = {{DATA_W{1'b0}}, blk};
    for (int i = 0; i < SH_W; i++) begin
      stg[i+1] = shamt[i] ? (stg[i] << (1 << i)) : stg[i];
    end
  end

  assign lo_mask = ~({DATA_W{1'b1}} << shamt);
  assign lo_vld  = lo_q & lo_mask;
  assign cat     = stg[SH_W] | {{BLK_W{1'b0}}, lo_vld};

  // top two bits of cat can never be reached by a shift of at most 62
  assign unused_cat = ^cat[CAT_W-1:2*DATA_W];

`ifdef PCS_TX_HEAD_CHECK_EN
  assign head_bad = (head_i == {HEAD_W{1'b0}}) | (&head_i);
`endif

  // next state: flush the full leftover, accept a block, or idle
  always_comb begin
    seq_d   = seq_q;
    lo_d    = lo_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef PCS_TX_HEAD_CHECK_EN
    herr_d  = 1'b0;
`endif
    unique case (1'b1)
      flush: begin
        data_d  = lo_q;
        valid_d = 1'b1;
        seq_d   = '0;
        lo_d    = '0;
      end
      accept: begin
        data_d  = cat[DATA_W-1:0];
        valid_d = 1'b1;
        lo_d    = cat[2*DATA_W-1:DATA_W];
        seq_d   = seq_q + 1'b1;
`ifdef PCS_TX_HEAD_CHECK_EN
        herr_d  = head_bad;
`endif
      end
      default: ;
    endcase
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      seq_q   <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef PCS_TX_HEAD_CHECK_EN
      herr_q  <= 1'b0;
`endif
    end else begin
      seq_q   <= seq_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef PCS_TX_HEAD_CHECK_EN
      herr_q  <= herr_d;
`endif
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
`ifdef PCS_TX_HEAD_CHECK_EN
  assign head_err_o = herr_q;
`endif

endmodule

// File: tb/tb_pcs_gearbox_tx.sv
// tb_pcs_gearbox_tx: directed table plus bit-queue model sequences
// for the 66b->64b TX gearbox.
module tb_pcs_gearbox_tx;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  head_i = '0;
  logic [63:0] data_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic [63:0] data_o;
`ifdef PCS_TX_HEAD_CHECK_EN
  logic        head_err_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcs_gearbox_tx dut (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .head_i  (head_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
`ifdef PCS_TX_HEAD_CHECK_EN
    .head_err_o (head_err_o),
`endif
    .data_o  (data_o)
  );

  typedef struct {
    logic        nres;
    logic        vld;
    logic [1:0]  head;
    logic [63:0] data;
    logic        e_rdy;
    logic        e_vld;
    logic [63:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic nres, input logic vld,
                       input logic [1:0] hd,
                       input logic [63:0] dt);
    @(negedge clk);
    nreset  = nres;
    valid_i = vld;
    head_i  = hd;
    data_i  = dt;
    #1;
  endtask

  // serial bitstream model: bit 0 of each word goes out first
  bit          q[$];
  int          mseq = 0;
  logic [1:0]  p_head;
  logic [63:0] p_data;
  logic [63:0] e_data = '0;

  function automatic logic [63:0] pop64();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (q.size() > 0) r[i] = q.pop_front();
    end
    return r;
  endfunction

  task automatic new_blk();
    p_head = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    p_data = {$urandom, $urandom};
  endtask

  task automatic cyc(input logic nres, input logic vld);
    logic        e_rdy;
    logic        e_vld;
    logic [65:0] blk;
`ifdef PCS_TX_HEAD_CHECK_EN
    logic        e_err;
    e_err = 1'b0;
`endif
    apply(nres, vld, p_head, p_data);
    e_rdy = nres && (mseq != 32);
    chk("ready_o", 64'(ready_o), 64'(e_rdy));
    e_vld = 1'b0;
    if (!nres) begin
      mseq = 0;
      q.delete();
      e_data = '0;
    end else if (mseq == 32) begin
      e_vld  = 1'b1;
      e_data = pop64();
      mseq   = 0;
    end else if (vld) begin
      blk = {p_data, p_head};
      for (int i = 0; i < 66; i++) q.push_back(blk[i]);
      e_vld  = 1'b1;
      e_data = pop64();
`ifdef PCS_TX_HEAD_CHECK_EN
      e_err = (p_head == 2'b00) || (p_head == 2'b11);
`endif
      mseq++;
      new_blk();
    end
    @(posedge clk);
    #1;
    chk("valid_o", 64'(valid_o), 64'(e_vld));
    chk("data_o", data_o, e_data);
`ifdef PCS_TX_HEAD_CHECK_EN
    chk("head_err_o", 64'(head_err_o), 64'(e_err));
`endif
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 2'b00, 64'h0,
               1'b0, 1'b0, 64'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 2'b01, 64'h0,
               1'b1, 1'b1, 64'h1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'b01, 64'h0,
               1'b0, 1'b0, 64'h0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 2'b10, 64'h0,
               1'b1, 1'b1, 64'hB, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 2'b01, 64'h5555,
               1'b1, 1'b0, 64'hB, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 2'b01, 64'h1234_5678_9ABC_DEF0,
               1'b1, 1'b1, 64'h8D15_9E26_AF37_BC10, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 2'b10, 64'h0,
               1'b1, 1'b1, 64'h84, 1'b0};

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].nres, tbl[i].vld, tbl[i].head, tbl[i].data);
      chk($sformatf("tbl%0d ready_o", i),
          64'(ready_o), 64'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d valid_o", i),
          64'(valid_o), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d data_o", i), data_o, tbl[i].e_data);
`ifdef PCS_TX_HEAD_CHECK_EN
      chk($sformatf("tbl%0d head_err_o", i),
          64'(head_err_o), 64'(tbl[i].e_err));
`endif
    end

    new_blk();

    // flush cadence: 66 cycles of continuous valid
    cyc(1'b0, 1'b0);
    for (int k = 1; k <= 66; k++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);

    // idle gap of 3 cycles at seq=5
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1);

    // reset mid-stream at seq=17
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 17; k++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1);

    // illegal then legal header
    cyc(1'b0, 1'b0);
    p_head = 2'b11;
    cyc(1'b1, 1'b1);
    p_head = 2'b10;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcs_gearbox_tx.md
Name: pcs_gearbox_tx

Overview:
TX gearbox that sits directly downstream of the 64b/66b scrambler. It packs a stream of 66-bit blocks into 64-bit words for the PMA/SerDes TX parallel interface. Each block is the 2-bit sync header plus the 64-bit scrambled payload. Every 32 input blocks yield 33 output words, so the block back-pressures upstream for one cycle in every 33.

Parameters:
DATA_W, 64, payload width and output word width; only 64 is supported.
HEAD_W, 2, sync header width; only 2 is supported.
SEQ_W, 6, width of the sequence counter; must hold the value 32.

Ports:
clk  input  1  clock
nreset  input  1  synchronous active-low reset
valid_i  input  1  upstream block valid
head_i  input  HEAD_W  sync header (2'b01 data, 2'b10 control)
data_i  input  DATA_W  scrambled payload
ready_o  output  1  gearbox accepts a block this cycle
valid_o  output  1  data_o carries a word
data_o  output  DATA_W  gearboxed word; bit 0 is transmitted first

Behaviour:
- Reset: nreset low at a clk edge is synchronous and active-low. It sets seq=0, leftover buffer=0, valid_o=0 and data_o=0. ready_o is forced 0 while nreset is low.
- Block format: blk[65:0] = {data_i, head_i}. The header occupies bits [1:0] and is transmitted first, LSB first.
- State: seq counts 0..32; leftover register lo[63:0] holds 2*seq valid bits in its low bits.
- ready_o is combinational: ready_o = nreset & (seq != 32).
- Accept: a block is accepted when valid_i & ready_o.
  - Compose 130 bits: c = (blk << 2*seq) | lo[2*seq-1:0].
  - Register data_o <= c[63:0] and valid_o <= 1.
  - Update lo <= c[129:64], which is 2*(seq+1) valid bits; upper bits are don't-care and are zeroed.
  - seq <= seq+1.
- Flush: when seq==32, regardless of valid_i:
  - data_o <= lo[63:0], valid_o <= 1.
  - seq <= 0, lo <= 0.
  - Upstream must hold its block; it is accepted on the next cycle.
- Idle: when seq!=32 and valid_i=0, valid_o <= 0. data_o, seq and lo hold their values.
- Latency: exactly 1 cycle from acceptance to data_o.
- Throughput: with continuous valid_i, valid_o stays 1 every cycle, and ready_o is 0 for exactly 1 cycle in every 33.
- Boundaries:
  - seq=0 is a no-leftover case: the shift is 0 and the block passes its low 64 bits.
  - The seq 31→32 transition leaves lo fully populated (64 bits).
  - The seq 32→0 wrap happens only via flush.
  - valid_i asserted while ready_o=0 has no effect.
  - Reset mid-stream discards the partial leftover. No partial word is emitted.
- Shift logic: the variable shift of 2*seq (0..62) is a barrel shifter on a 130-bit concatenation.

Optional Feature:
Macro PCS_TX_HEAD_CHECK_EN.
- Defined:
  - Adds output port head_err_o, 1 bit, reset 0.
  - head_err_o is registered and pulses 1 for one cycle, the same cycle as the corresponding data_o, when an accepted block has head_i equal to 2'b00 or 2'b11.
  - Flush cycles drive it 0.
  - The block is still transmitted unmodified.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Single-block path: after reset, accept head=2'b01, data=64'h0. Next cycle: valid_o=1, data_o=64'h0000_0000_0000_0001. seq=1, lo[1:0]=2'b00.
- Leftover carry:
  - Accept head=2'b01, data=64'hFFFF_FFFF_FFFF_FFFF. Expect data_o=64'hFFFF_FFFF_FFFF_FFFD.
  - Then accept head=2'b10, data=64'h0. Expect data_o=64'h0000_0000_0000_000B.
- Flush cadence:
  - Drive valid_i=1 continuously for 66 cycles with random data.
  - Expect ready_o=0 exactly at cycles 33 and 66 after reset release, and valid_o=1 on every cycle from 2 to 67.
  - The reassembled serial bitstream equals the concatenation of all {data,head} blocks.
- Idle gap: stall valid_i=0 for 3 cycles at seq=5. Expect valid_o=0 for 3 cycles and seq to stay 5. The next accepted block resumes the stream with no bit loss.
- Reset mid-stream: assert nreset=0 at seq=17 for 1 cycle. Next cycle: seq=0, valid_o=0, ready_o=1 after release, and the first block is output unshifted.
- With PCS_TX_HEAD_CHECK_EN: accept head=2'b11. Expect head_err_o=1 for one cycle aligned with its data_o. A head=2'b10 block yields head_err_o=0.
